// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types for the clock-generator pearl tag transmitter.
// RST_ONES/RST_ZEROS exist only when BSG_CLK_GEN_PEARL_TAG_TX_RESET_SEQ_EN is defined.
package bsg_clk_gen_pearl_pkg;

  // Field containers are sized for the widest supported build; narrower
  // builds zero-extend into them.
  localparam int pkt_payload_max_lp = 64;
  localparam int pkt_id_max_lp      = 16;
  localparam int pkt_len_max_lp     = 8;

  typedef struct packed {
    logic [pkt_payload_max_lp-1:0] payload;
    logic [pkt_id_max_lp-1:0]      node_id;
    logic                          data_not_reset;
    logic [pkt_len_max_lp-1:0]     len;
  } bsg_clk_gen_pearl_tag_tx_pkt_s;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_RESET_SEQ_EN
    , RST_ONES
    , RST_ZEROS
`endif
  } bsg_clk_gen_pearl_tag_tx_state_e;

  function automatic int safe_clog2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/bsg_clk_gen_pearl_tag_tx_clk_div.sv
// Free-running tag clock divider; fall_strobe marks the clk_i cycle in which
// tag_clk_o goes 1->0, which is the only cycle the transmitter may update pins.
module bsg_clk_gen_pearl_tag_tx_clk_div
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int clk_div_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic tag_clk_o,
  output logic fall_strobe
);

  localparam int cnt_w_lp = safe_clog2(clk_div_p);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(clk_div_p - 1);

  logic [cnt_w_lp-1:0] cnt;
  logic                wrap;

  assign wrap        = (cnt == last_lp);
  assign fall_strobe = wrap & tag_clk_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt       <= '0;
      tag_clk_o <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      tag_clk_o <= ~tag_clk_o;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_clk_gen_pearl_tag_tx.sv
// BSG tag packet serializer for the clock-generator pearl, LSB-first per field.
// Define BSG_CLK_GEN_PEARL_TAG_TX_RESET_SEQ_EN to emit the master reset sequence after reset.
module bsg_clk_gen_pearl_tag_tx
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int tag_els_p               = 16,
  parameter int tag_max_payload_width_p = 8,
  parameter int clk_div_p               = 4,
  parameter int gap_bits_p              = 1,
  parameter int reset_bits_p            = 64,
  localparam int lg_els_lp   = safe_clog2(tag_els_p),
  localparam int lg_width_lp = safe_clog2(tag_max_payload_width_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               v_i,
  output logic                               ready_and_o,
  input  logic [lg_els_lp-1:0]               node_id_i,
  input  logic                               data_not_reset_i,
  input  logic [lg_width_lp-1:0]             len_i,
  input  logic [tag_max_payload_width_p-1:0] payload_i,
  output logic                               tag_clk_o,
  output logic                               tag_data_o,
  output logic                               tag_en_o,
  output logic                               busy_o
);

  localparam int hdr_lp   = 2 + lg_width_lp + lg_els_lp;
  localparam int sr_w_lp  = hdr_lp + tag_max_payload_width_p;
  localparam int cnt_max_lp = (sr_w_lp > gap_bits_p)
                            ? ((sr_w_lp > reset_bits_p) ? sr_w_lp : reset_bits_p)
                            : ((gap_bits_p > reset_bits_p) ? gap_bits_p : reset_bits_p);
  localparam int cnt_w_lp = safe_clog2(cnt_max_lp);
  localparam logic [cnt_w_lp-1:0] gap_load_lp = cnt_w_lp'(gap_bits_p - 1);

`ifdef BSG_CLK_GEN_PEARL_TAG_TX_RESET_SEQ_EN
  localparam logic [cnt_w_lp-1:0] rst_load_lp = cnt_w_lp'(reset_bits_p - 1);
  localparam bsg_clk_gen_pearl_tag_tx_state_e reset_state_lp = RST_ONES;
`else
  localparam logic [cnt_w_lp-1:0] rst_load_lp = '0;
  localparam bsg_clk_gen_pearl_tag_tx_state_e reset_state_lp = IDLE;
`endif

  bsg_clk_gen_pearl_tag_tx_state_e state;
  bsg_clk_gen_pearl_tag_tx_pkt_s   pkt;
  logic [lg_width_lp-1:0]          len_c;
  logic [sr_w_lp-1:0]              vec, shift;
  logic [cnt_w_lp-1:0]             cnt, cnt_load;
  logic                            fall, accept;

  bsg_clk_gen_pearl_tag_tx_clk_div #(.clk_div_p(clk_div_p)) div (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .tag_clk_o   (tag_clk_o),
    .fall_strobe (fall)
  );

  assign accept = v_i & ready_and_o & (state == IDLE);

  // Flatten the request into wire order: start, len, dnr, node_id, payload.
  always_comb begin
    pkt = '0;
    pkt.payload[tag_max_payload_width_p-1:0] = payload_i;
    pkt.node_id[lg_els_lp-1:0]               = node_id_i;
    pkt.data_not_reset                       = data_not_reset_i;
    pkt.len[lg_width_lp-1:0]                 = len_i;
    if (pkt.len > pkt_len_max_lp'(tag_max_payload_width_p))
      len_c = lg_width_lp'(tag_max_payload_width_p);
    else
      len_c = pkt.len[lg_width_lp-1:0];
    vec = '0;
    vec[0]                               = 1'b1;
    vec[1 +: lg_width_lp]                = len_c;
    vec[1 + lg_width_lp]                 = pkt.data_not_reset;
    vec[2 + lg_width_lp +: lg_els_lp]    = pkt.node_id[lg_els_lp-1:0];
    vec[hdr_lp +: tag_max_payload_width_p] = pkt.payload[tag_max_payload_width_p-1:0];
    cnt_load = cnt_w_lp'(hdr_lp - 1) + cnt_w_lp'(len_c);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= reset_state_lp;
      cnt         <= rst_load_lp;
      shift       <= '0;
      tag_data_o  <= 1'b0;
      tag_en_o    <= 1'b0;
      ready_and_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
          end
          if (accept) begin
            shift       <= vec;
            cnt         <= cnt_load;
            state       <= SEND;
            ready_and_o <= 1'b0;
            busy_o      <= 1'b1;
          end else begin
            ready_and_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        SEND: if (fall) begin
          tag_data_o <= shift[0];
          tag_en_o   <= 1'b1;
          shift      <= shift >> 1;
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= gap_load_lp;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Reopening during the last gap bit lets a waiting packet start on the next fall.
        GAP: if (fall) begin
          tag_data_o <= 1'b0;
          tag_en_o   <= 1'b1;
          if (cnt == '0) begin
            state       <= IDLE;
            ready_and_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_RESET_SEQ_EN
        RST_ONES: begin
          busy_o <= 1'b1;
          if (fall) begin
            tag_data_o <= 1'b1;
            tag_en_o   <= 1'b1;
            if (cnt == '0) begin
              state <= RST_ZEROS;
              cnt   <= rst_load_lp;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        RST_ZEROS: begin
          busy_o <= 1'b1;
          if (fall) begin
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b1;
            if (cnt == '0) begin
              state       <= IDLE;
              ready_and_o <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_tx.sv
// Scoreboard bench for bsg_clk_gen_pearl_tag_tx: expected tag bits are queued at accept
// and a monitor on tag_clk_o rising edges compares them, plus tag_en run lengths.
module tb_bsg_clk_gen_pearl_tag_tx;
  localparam int CLK_DIV = 2;
  localparam int MAXW    = 8;
  localparam int GAPB    = 1;
  localparam int RBITS   = 8;
  localparam int LGW     = 4;
  localparam int LGE     = 4;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b1;
  logic v_i = 1'b0;
  logic data_not_reset_i = 1'b0;
  logic [LGE-1:0] node_id_i = '0;
  logic [LGW-1:0] len_i = '0;
  logic [MAXW-1:0] payload_i = '0;
  logic ready_and_o, tag_clk_o, tag_data_o, tag_en_o, busy_o;

  bsg_clk_gen_pearl_tag_tx #(
    .tag_els_p(16), .tag_max_payload_width_p(MAXW), .clk_div_p(CLK_DIV),
    .gap_bits_p(GAPB), .reset_bits_p(RBITS)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .node_id_i(node_id_i), .data_not_reset_i(data_not_reset_i), .len_i(len_i),
    .payload_i(payload_i), .tag_clk_o(tag_clk_o), .tag_data_o(tag_data_o),
    .tag_en_o(tag_en_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit data; bit gap; } exp_bit_t;
  exp_bit_t exp_q[$];
  int run_q[$];
  int run_len = 0, bits_seen = 0, burst_len = 0;
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push_bit(input bit d, input bit g);
    exp_bit_t e;
    e.data = d;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  // Reference packet: what the pins must carry for one accepted request.
  task automatic push_pkt(input int node, input bit dnr, input int len, input int pay, output int n);
    int l;
    l = (len > MAXW) ? MAXW : len;
    push_bit(1'b1, 1'b0);
    for (int i = 0; i < LGW; i++) push_bit(bit'((l >> i) & 1), 1'b0);
    push_bit(dnr, 1'b0);
    for (int i = 0; i < LGE; i++) push_bit(bit'((node >> i) & 1), 1'b0);
    for (int i = 0; i < l; i++) push_bit(bit'((pay >> i) & 1), 1'b0);
    for (int i = 0; i < GAPB; i++) push_bit(1'b0, 1'b1);
    n = 2 + LGW + LGE + l + GAPB;
  endtask

  // Monitor: every tag_clk rise, consume one expected bit when tag_en is high.
  initial begin
    exp_bit_t e;
    forever begin
      @(posedge tag_clk_o);
      #1;
      if (tag_en_o) begin
        run_len++;
        bits_seen++;
        if (exp_q.size() == 0) fail_now("unexpected_tag_bit");
        else begin
          e = exp_q.pop_front();
          check("tag_data", tag_data_o, e.data);
          if (!e.gap) check("ready_low_in_pkt", ready_and_o, 0);
        end
      end else begin
        check("idle_data_zero", tag_data_o, 0);
        if (run_len > 0) begin
          if (run_q.size() == 0) fail_now("unexpected_en_run");
          else check("en_run_len", run_len, run_q.pop_front());
          run_len = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int node, input bit dnr, input int len, input int pay);
    bit ok;
    int n;
    node_id_i = LGE'(node);
    data_not_reset_i = dnr;
    len_i = LGW'(len);
    payload_i = MAXW'(pay);
    v_i = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (ready_and_o) begin
        @(posedge clk_i);
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (ok) begin
      push_pkt(node, dnr, len, pay, n);
      burst_len += n;
    end else fail_now("accept_timeout");
    @(negedge clk_i);
  endtask

  task automatic end_burst();
    bit ok;
    v_i = 1'b0;
    run_q.push_back(burst_len);
    burst_len = 0;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk_i);
      if (!busy_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
    repeat (4 * CLK_DIV * 2) @(negedge clk_i);
  endtask

  task automatic do_reset(input int hold);
    reset_n_i = 1'b0;
    v_i = 1'b0;
    #1;
    exp_q.delete();
    run_q.delete();
    run_len = 0;
    burst_len = 0;
    check("rst_tag_en", tag_en_o, 0);
    check("rst_tag_data", tag_data_o, 0);
    check("rst_tag_clk", tag_clk_o, 0);
    check("rst_ready", ready_and_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (hold) begin
      @(negedge clk_i);
      if (tag_clk_o || tag_en_o || tag_data_o || ready_and_o || busy_o)
        fail_now("outputs_nonzero_in_reset");
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_RESET_SEQ_EN
    for (int i = 0; i < RBITS; i++) push_bit(1'b1, 1'b0);
    for (int i = 0; i < RBITS; i++) push_bit(1'b0, i == RBITS - 1);
    run_q.push_back(2 * RBITS);
    @(posedge clk_i);
    #1;
    check("ready_during_seq", ready_and_o, 0);
    check("busy_during_seq", busy_o, 1);
    begin
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 4 * CLK_DIV * RBITS + 40; t++) begin
        @(negedge clk_i);
        if (ready_and_o) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("reset_seq_timeout");
      check("seq_bits_drained", exp_q.size(), 1);
    end
    repeat (4 * CLK_DIV) @(negedge clk_i);
`else
    @(posedge clk_i);
    #1;
    check("ready_after_reset", ready_and_o, 1);
    check("busy_after_reset", busy_o, 0);
    @(negedge clk_i);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, base;
    logic prev;
    bit ok;
    #2;
    do_reset(10);

    // Tag clock period from two consecutive rises.
    c1 = -1;
    c2 = -1;
    prev = tag_clk_o;
    for (int c = 0; c < 100 && c2 < 0; c++) begin
      @(posedge clk_i);
      #1;
      if (!prev && tag_clk_o) begin
        if (c1 < 0) c1 = c;
        else c2 = c;
      end
      prev = tag_clk_o;
    end
    if (c2 < 0) fail_now("tag_clk_not_toggling");
    else check("tag_clk_period", c2 - c1, 2 * CLK_DIV);
    @(negedge clk_i);

    // Directed single packet.
    issue(3, 1'b1, 2, 8'b10);
    end_burst();

    // Back-to-back pair: must form one contiguous tag_en run.
    issue($urandom_range(15), 1'($urandom), $urandom_range(8), $urandom_range(255));
    issue($urandom_range(15), 1'($urandom), $urandom_range(8), $urandom_range(255));
    end_burst();

    // Length clamp and empty payload.
    issue($urandom_range(15), 1'b1, 15, $urandom_range(255));
    end_burst();
    issue($urandom_range(15), 1'b0, 0, $urandom_range(255));
    end_burst();

    // Random bursts.
    for (int b = 0; b < 8; b++) begin
      int k;
      k = $urandom_range(1, 3);
      for (int p = 0; p < k; p++)
        issue($urandom_range(15), 1'($urandom), $urandom_range(15), $urandom_range(255));
      end_burst();
    end

    // Abort after five transmitted bits.
    base = bits_seen;
    issue(5, 1'b1, 8, $urandom_range(255));
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (bits_seen >= base + 5) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) fail_now("mid_packet_wait_timeout");
    @(negedge clk_i);
    #2;
    do_reset(4);

    // Still usable after the abort.
    issue($urandom_range(15), 1'b1, $urandom_range(8), $urandom_range(255));
    end_burst();

    check("exp_q_drained", exp_q.size(), 0);
    check("run_q_drained", run_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
